dpram_fifo_ctrl: RTL and testbench
==================================

# dpram_fifo_ctrl

Synchronous FIFO controller that sits directly in front of the 32x4 dual-port distributed RAM (`raminfr`: synchronous write through `we`/`a`/`di`, asynchronous read through `dpra`/`dpo`). It turns that RAM into a 32-entry first-in-first-out queue. It owns the write and read pointers, occupancy count, full/empty flags and the registered read-data stage. The RAM itself stays outside this block; this block drives the RAM's write port and read address and consumes `dpo`.

## Interface
Parameters:
- `DW`, 4, data width; must match RAM `di`/`dpo` width.
- `AW`, 5, address width; depth is 2**AW = 32.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `wr_en`  in  1  push request.
- `wr_data`  in  DW  push data.
- `rd_en`  in  1  pop request.
- `rd_data`  out  DW  popped data, registered.
- `rd_valid`  out  1  `rd_data` holds a newly popped word this cycle.
- `full`  out  1  count == 2**AW.
- `empty`  out  1  count == 0.
- `count`  out  AW+1  occupancy, 0..32.
- `overflow`  out  1  one-cycle pulse when a push was rejected.
- `underflow`  out  1  one-cycle pulse when a pop was rejected.
- `ram_we`  out  1  to RAM `we`.
- `ram_a`  out  AW  to RAM `a`; always equals the write pointer.
- `ram_di`  out  DW  to RAM `di`; equals `wr_data`.
- `ram_dpra`  out  AW  to RAM `dpra`; always equals the read pointer.
- `ram_dpo`  in  DW  from RAM `dpo`; asynchronous read data.

## Operation
- Acceptance uses start-of-cycle state:
  - `push = wr_en & ~full`
  - `pop = rd_en & ~empty`
- RAM write port is combinational:
  - `ram_we = push`
  - `ram_a = wptr`
  - `ram_di = wr_data`
  - The RAM writes on the same rising edge.
- On `push`, `wptr` increments modulo 32.
- On `pop`:
  - `rd_data <= ram_dpo`, which is the word at `rptr`.
  - `rptr` increments modulo 32.
  - `rd_valid <= 1`.
- On a cycle without `pop`, `rd_valid <= 0` and `rd_data` holds its last value.
- Count update:
  - `push` only: +1.
  - `pop` only: −1.
  - Both, or neither: unchanged.
- `full` and `empty` are registered and derived from the next count value. They are never computed from pointer comparison alone.
- Simultaneous push and pop:
  - When neither full nor empty, both are accepted and the count is unchanged.
  - When full, only the pop is accepted; the push is rejected and `overflow` pulses.
  - When empty, only the push is accepted; there is no bypass, so the word becomes readable the next cycle.
- Rejected operations:
  - `overflow <= wr_en & full`.
  - `underflow <= rd_en & empty`.
  - A rejected operation changes no pointer, count or data.
- Pointer wrap: the 31→0 transition is seamless and has no effect on the flags.
- Reset (any cycle, including mid-burst):
  - `wptr`, `rptr` and `count` go to 0.
  - `empty = 1`, `full = 0`.
  - `rd_data = 0`, `rd_valid = 0`, `overflow = 0`, `underflow = 0`.
  - `ram_we` is forced to 0 while `rst` is high.
  - RAM contents are not cleared but are unreachable afterwards.
  - Inputs during a reset cycle are ignored.

## Timing
- Write latency: a push at edge N is visible to a pop at edge N+1 or later.
- Read latency: a pop accepted at edge N gives `rd_data` and `rd_valid` valid after edge N, for exactly one cycle per pop.
- Back-to-back pops give one word per cycle, with `rd_valid` held high continuously.
- `count`, `full` and `empty` reflect all operations up to and including the last edge. There is no combinational path from `wr_en`/`rd_en` to the flags.
- The only combinational outputs are `ram_we`, `ram_a`, `ram_di` and `ram_dpra`.
- The single combinational input path is `ram_dpo` → `rd_data` D-input.

## Test plan
- Reset, then push 4'b1010, 4'b1100, 4'b1111 on consecutive cycles.
  - Required: `count` goes 1, 2, 3 and `empty` drops after the first edge.
  - Then three pops give `rd_data` 1010, 1100, 1111 with `rd_valid` high for 3 cycles, ending with `count = 0` and `empty = 1`.
- Push 32 words (0..15 twice).
  - Required: `full = 1` and `count = 32`.
  - A 33rd push gives `overflow` for 1 cycle with `count` still 32.
  - 32 pops return the original order across the pointer wrap.
- When full, assert `wr_en` and `rd_en` together.
  - Required: only the pop is accepted, `count = 31`, `overflow` pulses, and the first-written word is returned.
- When empty, assert `wr_en` and `rd_en` together with data 4'b0110.
  - Required: `underflow` pulses, `rd_valid = 0`, and `count = 1`.
  - The next-cycle pop returns 0110.
- With `count = 16`, run steady simultaneous push and pop for 40 cycles.
  - Required: `count` stays 16 and the data stream is delayed exactly 16 entries.
- Assert `rst` for one cycle mid-burst with `count = 10`.
  - Required: all outputs at their reset values the next cycle.
  - A subsequent push of 4'b0011 then pop returns 0011.

Source files
------------

// File: rtl/dpram_fifo_ctrl_if.sv
// User-side bundle of the FIFO controller: push/pop requests plus status.
//
// Request semantics: wr_en and rd_en are plain requests with no ready
// signal in return. A request is taken on the rising edge only if the
// start-of-cycle flags permit it. A push is taken when ~full and a pop
// is taken when ~empty. A refused request raises overflow/underflow for
// exactly one cycle after that edge. A taken pop presents its word on
// rd_data with rd_valid high for the cycle after the edge.
interface dpram_fifo_ctrl_if #(
    parameter int DW = 4,
    parameter int AW = 5
);
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;

    // Producer/consumer side (drives requests, observes status).
    modport master (
        output wr_en, wr_data, rd_en,
        input  rd_data, rd_valid, full, empty, count, overflow, underflow
    );

    // FIFO controller side.
    modport slave (
        input  wr_en, wr_data, rd_en,
        output rd_data, rd_valid, full, empty, count, overflow, underflow
    );
endinterface

// File: rtl/dpram_fifo_ctrl.sv
// FIFO controller wrapped around an external 2**AW x DW dual-port RAM with
// synchronous write and asynchronous read. This block owns the pointers,
// the occupancy count, the flags and the registered read-data stage.
module dpram_fifo_ctrl #(
    parameter int DW = 4,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    dpram_fifo_ctrl_if.slave fif,
    output logic          ram_we,
    output logic [AW-1:0] ram_a,
    output logic [DW-1:0] ram_di,
    output logic [AW-1:0] ram_dpra,
    input  logic [DW-1:0] ram_dpo
);
    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic [DW-1:0] rd_data_q, rd_data_d;
    logic          rd_valid_q, rd_valid_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;
    logic          push, pop;

    // Acceptance from start-of-cycle flags, then next-state for every register.
    always_comb begin
        push        = fif.wr_en & ~full_q;
        pop         = fif.rd_en & ~empty_q;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = pop;
        if (push) wptr_d = wptr_q + 1'b1;
        if (pop) begin
            rptr_d    = rptr_q + 1'b1;
            rd_data_d = ram_dpo;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // Flags come from the next count, never from pointer equality.
        full_d      = (count_d == DEPTH);
        empty_d     = (count_d == '0);
        overflow_d  = fif.wr_en & full_q;
        underflow_d = fif.rd_en & empty_q;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // RAM port drive: the write is suppressed while reset is asserted.
    always_comb begin
        ram_we   = push & ~rst;
        ram_a    = wptr_q;
        ram_di   = fif.wr_data;
        ram_dpra = rptr_q;
    end

    // Status outputs straight from registers.
    always_comb begin
        fif.rd_data   = rd_data_q;
        fif.rd_valid  = rd_valid_q;
        fif.full      = full_q;
        fif.empty     = empty_q;
        fif.count     = count_q;
        fif.overflow  = overflow_q;
        fif.underflow = underflow_q;
    end
endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Bench for dpram_fifo_ctrl with a behavioural model of the 32x4 RAM.
module tb_dpram_fifo_ctrl;
    localparam int DW = 4;
    localparam int AW = 5;

    logic          clk;
    logic          rst;
    logic          ram_we;
    logic [AW-1:0] ram_a;
    logic [DW-1:0] ram_di;
    logic [AW-1:0] ram_dpra;
    logic [DW-1:0] ram_dpo;
    logic [DW-1:0] mem [32];

    int errors = 0;
    int checks = 0;
    logic we_seen;
    logic [DW-1:0] exp_q[$];

    dpram_fifo_ctrl_if #(.DW(DW), .AW(AW)) fif ();

    dpram_fifo_ctrl #(.DW(DW), .AW(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .fif      (fif),
        .ram_we   (ram_we),
        .ram_a    (ram_a),
        .ram_di   (ram_di),
        .ram_dpra (ram_dpra),
        .ram_dpo  (ram_dpo)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: synchronous write, asynchronous read.
    always @(posedge clk) if (ram_we) mem[ram_a] <= ram_di;
    assign ram_dpo = mem[ram_dpra];

    typedef struct {
        logic          r;
        logic          wr;
        logic          rd;
        logic [DW-1:0] wd;
        logic          e_we;
        logic          e_rv;
        logic [DW-1:0] e_rd;
        logic [AW:0]   e_cnt;
        logic          e_full;
        logic          e_empty;
        logic          e_ovf;
        logic          e_unf;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: drive at negedge, capture ram_we before the edge, return #1 after it.
    task automatic cycle(input logic r, input logic wr, input logic rd, input logic [DW-1:0] wd);
        @(negedge clk);
        rst         = r;
        fif.wr_en   = wr;
        fif.rd_en   = rd;
        fif.wr_data = wd;
        #1;
        we_seen = ram_we;
        @(posedge clk);
        #1;
    endtask

    task automatic check_status(input string tag, input logic [AW:0] cnt, input logic f,
                                input logic e, input logic ovf, input logic unf);
        check({tag, " count"}, 32'(fif.count), 32'(cnt));
        check({tag, " full"}, 32'(fif.full), 32'(f));
        check({tag, " empty"}, 32'(fif.empty), 32'(e));
        check({tag, " overflow"}, 32'(fif.overflow), 32'(ovf));
        check({tag, " underflow"}, 32'(fif.underflow), 32'(unf));
    endtask

    initial begin
        logic [DW-1:0] d;
        for (int i = 0; i < 32; i++) mem[i] = '0;
        rst = 1'b1;
        fif.wr_en = 1'b0;
        fif.rd_en = 1'b0;
        fif.wr_data = '0;

        // r wr rd wd | we rv rd cnt full empty ovf unf
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 4'h5, 1'b0, 1'b0, 4'h0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 4'ha, 1'b1, 1'b0, 4'h0, 6'd1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 4'hc, 1'b1, 1'b0, 4'h0, 6'd2, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 4'hf, 1'b1, 1'b0, 4'h0, 6'd3, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 4'h0, 1'b0, 1'b1, 4'ha, 6'd2, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 4'h0, 1'b0, 1'b1, 4'hc, 6'd1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 4'h0, 1'b0, 1'b1, 4'hf, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'hf, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 4'hf, 6'd0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 4'h6, 1'b1, 1'b0, 4'hf, 6'd1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 4'h0, 1'b0, 1'b1, 4'h6, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h6, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0};

        for (int i = 0; i < 12; i++) begin
            cycle(vecs[i].r, vecs[i].wr, vecs[i].rd, vecs[i].wd);
            check($sformatf("v%0d ram_we", i), 32'(we_seen), 32'(vecs[i].e_we));
            check($sformatf("v%0d rd_valid", i), 32'(fif.rd_valid), 32'(vecs[i].e_rv));
            check($sformatf("v%0d rd_data", i), 32'(fif.rd_data), 32'(vecs[i].e_rd));
            check_status($sformatf("v%0d", i), vecs[i].e_cnt, vecs[i].e_full,
                         vecs[i].e_empty, vecs[i].e_ovf, vecs[i].e_unf);
        end

        // Fill to full with 0..15 twice, starting from a fresh reset.
        cycle(1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 32; i++) cycle(1'b0, 1'b1, 1'b0, 4'(i % 16));
        check_status("fill", 6'd32, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 4'h7);
        check("push33 ram_we", 32'(we_seen), 32'd0);
        check_status("push33", 6'd32, 1'b1, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, '0);
        check_status("after33", 6'd32, 1'b1, 1'b0, 1'b0, 1'b0);

        // Push and pop together while full: only the pop is taken.
        cycle(1'b0, 1'b1, 1'b1, 4'h9);
        check("fullboth ram_we", 32'(we_seen), 32'd0);
        check("fullboth rd_valid", 32'(fif.rd_valid), 32'd1);
        check("fullboth rd_data", 32'(fif.rd_data), 32'd0);
        check_status("fullboth", 6'd31, 1'b0, 1'b0, 1'b1, 1'b0);

        // Drain the rest across the read-pointer wrap.
        for (int j = 1; j < 32; j++) begin
            cycle(1'b0, 1'b0, 1'b1, '0);
            check($sformatf("drain%0d rd_data", j), 32'(fif.rd_data), 32'(j % 16));
            check($sformatf("drain%0d rd_valid", j), 32'(fif.rd_valid), 32'd1);
        end
        check_status("drained", 6'd0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Preload 16 entries, then 40 cycles of simultaneous push/pop.
        for (int k = 0; k < 16; k++) begin
            d = 4'((k * 5 + 1) % 16);
            exp_q.push_back(d);
            cycle(1'b0, 1'b1, 1'b0, d);
        end
        check("pre16 count", 32'(fif.count), 32'd16);
        for (int k = 0; k < 40; k++) begin
            d = 4'((k * 3 + 2) % 16);
            exp_q.push_back(d);
            cycle(1'b0, 1'b1, 1'b1, d);
            check($sformatf("steady%0d rd_data", k), 32'(fif.rd_data), 32'(exp_q.pop_front()));
            check($sformatf("steady%0d count", k), 32'(fif.count), 32'd16);
            check($sformatf("steady%0d rd_valid", k), 32'(fif.rd_valid), 32'd1);
        end

        // Pop down to 10 entries, then reset mid-burst with requests active.
        for (int k = 0; k < 6; k++) begin
            cycle(1'b0, 1'b0, 1'b1, '0);
            check($sformatf("pop6_%0d rd_data", k), 32'(fif.rd_data), 32'(exp_q.pop_front()));
        end
        check("pre_rst count", 32'(fif.count), 32'd10);
        cycle(1'b1, 1'b1, 1'b1, 4'hd);
        exp_q.delete();
        check("rst ram_we", 32'(we_seen), 32'd0);
        check("rst rd_data", 32'(fif.rd_data), 32'd0);
        check("rst rd_valid", 32'(fif.rd_valid), 32'd0);
        check_status("rst", 6'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 4'h3);
        check_status("post_rst push", 6'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, '0);
        check("post_rst rd_data", 32'(fif.rd_data), 32'd3);
        check("post_rst rd_valid", 32'(fif.rd_valid), 32'd1);
        check_status("post_rst pop", 6'd0, 1'b0, 1'b1, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
